// File: rtl/i2s_master.sv
// I2S bus master.
// Generates BCLK/LRCLK from the system clock and shifts DAC pairs out MSB first.
// Shifts ADC pairs in the same way, one {left, right} word per frame on each
// valid/ready stream.
module i2s_master #(
    parameter int BIT_DEPTH   = 24,
    parameter int SLOT_BITS   = 32,
    parameter int HALF_PERIOD = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   sdata_o,
    input  logic                   sdata_i,
    input  logic                   dac_sample_valid,
    output logic                   dac_sample_ready,
    input  logic [2*BIT_DEPTH-1:0] dac_sample_data,
    output logic                   adc_sample_valid,
    input  logic                   adc_sample_ready,
    output logic [2*BIT_DEPTH-1:0] adc_sample_data,
    output logic                   underrun,
    output logic                   overrun
);

    localparam int W     = 2 * BIT_DEPTH;
    localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_L   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DEPTH_L  = BIT_W'(BIT_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic [W-1:0]     tx_shift_q, tx_shift_d;
    logic [W-1:0]     rx_shift_q, rx_shift_d;
    logic [W-1:0]     hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             adc_valid_q, adc_valid_d;
    logic [W-1:0]     adc_data_q, adc_data_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;

    logic             run_active;
    logic             tick;
    logic             rise;
    logic             fall;
    logic             boundary;
    logic             stopping;
    logic [BIT_W-1:0] bit_next;
    logic [BIT_W-1:0] p_cur;
    logic [BIT_W-1:0] p_next;
    logic             load_tx;

    // Position of a bit counter value within its channel slot.
    function automatic logic [BIT_W-1:0] slot_pos(input logic [BIT_W-1:0] b);
        return (b >= SLOT_L) ? (b - SLOT_L) : b;
    endfunction

    // Data positions inside a slot: one BCLK after the lrclk edge, BIT_DEPTH bits.
    function automatic logic in_data(input logic [BIT_W-1:0] p);
        return (p != '0) && (p <= DEPTH_L);
    endfunction

    assign run_active = (state_q != ST_IDLE);
    assign tick       = run_active && (div_cnt_q == DIV_LAST);
    assign rise       = tick && !bclk_q;
    assign fall       = tick && bclk_q;
    assign bit_next   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    assign boundary   = fall && (bit_cnt_q == BIT_LAST);
    assign stopping   = (state_q == ST_STOP) && !enable;
    assign p_cur      = slot_pos(bit_cnt_q);
    assign p_next     = slot_pos(bit_next);

    // Next-state logic for run control, clock generation, shifting and both streams.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which is what keeps this free of latches.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        adc_valid_d = adc_valid_q;
        adc_data_d  = adc_data_q;
        underrun_d  = 1'b0;
        overrun_d   = 1'b0;
        load_tx     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    load_tx = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (enable)        state_d = ST_RUN;
                else if (boundary) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (run_active) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) bclk_d = !bclk_q;

            // The slave drives on the falling edge, so the bit is stable at the rising edge.
            if (rise && in_data(p_cur)) rx_shift_d = {rx_shift_q[W-2:0], sdata_i};

            if (fall) begin
                bit_cnt_d = bit_next;
                lrclk_d   = (bit_next >= SLOT_L);
                if (in_data(p_next)) begin
                    sdata_d    = tx_shift_q[W-1];
                    tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
                end else begin
                    sdata_d = 1'b0;
                end
            end

            // A stop that is still requested at the boundary ends the link without a new load.
            if (boundary && !stopping) load_tx = 1'b1;
        end

        if (load_tx) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
            hold_full_d = 1'b0;
        end

        // Ready is only high while the holding register is empty, so a
        // handshake never collides with a word still waiting to be loaded.
        if (dac_sample_valid && !hold_full_q) begin
            hold_d      = dac_sample_data;
            hold_full_d = 1'b1;
        end

        if (adc_valid_q && adc_sample_ready) adc_valid_d = 1'b0;
        // A boundary in the same cycle as a handshake wins: the new word stays valid.
        if (boundary) begin
            adc_data_d  = rx_shift_q;
            adc_valid_d = 1'b1;
            if (adc_valid_q && !adc_sample_ready) overrun_d = 1'b1;
        end
    end

    // State registers; asynchronous reset drops every output and discards held words.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            adc_valid_q <= 1'b0;
            adc_data_q  <= '0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            adc_valid_q <= adc_valid_d;
            adc_data_q  <= adc_data_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bclk             = bclk_q;
    assign lrclk            = lrclk_q;
    assign sdata_o          = sdata_q;
    assign dac_sample_ready = !hold_full_q;
    assign adc_sample_valid = adc_valid_q;
    assign adc_sample_data  = adc_data_q;
    assign underrun         = underrun_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master at BIT_DEPTH=24, SLOT_BITS=32, HALF_PERIOD=2.
// Cycle n counts clk periods from the first cycle in RUN; bit b spans n = 4b..4b+3.
module tb_i2s_master;

    localparam int BD = 24;
    localparam int SB = 32;
    localparam int HP = 2;
    localparam int W  = 2 * BD;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         bclk, lrclk, sdata_o, sdata_i;
    logic         dac_valid = 1'b0;
    logic         dac_ready;
    logic [W-1:0] dac_data = '0;
    logic         adc_valid;
    logic         adc_ready = 1'b0;
    logic [W-1:0] adc_data;
    logic         underrun, overrun;
    logic         loop_en = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int   n;
        logic bclk;
        logic lrclk;
        logic sdata;
        logic adc_valid;
        logic underrun;
    } vec_t;

    vec_t vecs[$];

    assign sdata_i = loop_en & sdata_o;

    always #5 clk = ~clk;

    i2s_master #(.BIT_DEPTH(BD), .SLOT_BITS(SB), .HALF_PERIOD(HP)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .bclk             (bclk),
        .lrclk            (lrclk),
        .sdata_o          (sdata_o),
        .sdata_i          (sdata_i),
        .dac_sample_valid (dac_valid),
        .dac_sample_ready (dac_ready),
        .dac_sample_data  (dac_data),
        .adc_sample_valid (adc_valid),
        .adc_sample_ready (adc_ready),
        .adc_sample_data  (adc_data),
        .underrun         (underrun),
        .overrun          (overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        dac_valid = 1'b0;
        adc_ready = 1'b0;
        loop_en   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One handshake into the DAC holding register, starting and ending on a falling clk edge.
    task automatic offer_dac(input logic [W-1:0] word);
        dac_valid = 1'b1;
        dac_data  = word;
        @(negedge clk);
        dac_valid = 1'b0;
    endtask

    initial begin
        int vi;
        int lr_bad;
        int lr_high;
        int ur_cnt;
        int sd_ones;
        int bclk_hi;
        int vcnt;
        logic prev_b;
        logic prev_l;

        // cycle, bclk, lrclk, sdata_o, adc valid, underrun for frame 1 of {ABCDEF, 123456}
        vecs.push_back('{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{6,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{12,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{96,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{127, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{128, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{132, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{144, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{220, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{224, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{256, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{257, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        // Reset state
        do_reset();
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_sdata", sdata_o, 0);
        check("rst_dac_ready", dac_ready, 1);
        check("rst_adc_valid", adc_valid, 0);
        check("rst_adc_data", adc_data, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);

        // Loopback with a word held before enable; adc_ready held low across two frames
        loop_en = 1'b1;
        offer_dac({24'hABCDEF, 24'h123456});
        check("idle_hs_ready_low", dac_ready, 0);
        enable  = 1'b1;
        vi      = 0;
        lr_bad  = 0;
        lr_high = 0;
        ur_cnt  = 0;
        sd_ones = 0;
        prev_b  = 1'b0;
        prev_l  = 1'b0;
        for (int n = 0; n <= 512; n++) begin
            @(negedge clk);
            while (vi < vecs.size() && vecs[vi].n == n) begin
                check($sformatf("vec%0d_bclk", n), bclk, vecs[vi].bclk);
                check($sformatf("vec%0d_lrclk", n), lrclk, vecs[vi].lrclk);
                check($sformatf("vec%0d_sdata", n), sdata_o, vecs[vi].sdata);
                check($sformatf("vec%0d_adc_valid", n), adc_valid, vecs[vi].adc_valid);
                check($sformatf("vec%0d_underrun", n), underrun, vecs[vi].underrun);
                vi++;
            end
            if (n == 0) check("run_entry_ready", dac_ready, 1);
            if (n == 256) begin
                check("loop_word", adc_data, {24'hABCDEF, 24'h123456});
                check("loop_no_overrun", overrun, 0);
            end
            if (n > 0 && lrclk !== prev_l && !(prev_b == 1'b1 && bclk == 1'b0)) lr_bad++;
            if (n < 256 && lrclk) lr_high++;
            if (n > 256 && n < 512 && sdata_o) sd_ones++;
            if (n > 256 && underrun) ur_cnt++;
            prev_b = bclk;
            prev_l = lrclk;
        end
        check("lrclk_on_fall_only", lr_bad, 0);
        check("lrclk_high_cycles", lr_high, 128);
        check("empty_frame_sdata_zero", sd_ones, 0);
        check("underrun_once", ur_cnt, 1);
        check("overrun_pulse", overrun, 1);
        check("overrun_valid", adc_valid, 1);
        check("overrun_data_new", adc_data, 0);
        adc_ready = 1'b1;
        @(negedge clk);
        check("valid_drop_after_hs", adc_valid, 0);
        check("overrun_one_cycle", overrun, 0);

        // Stop requested at bit_cnt=10: frame finishes, word delivered, clocks park low
        do_reset();
        loop_en = 1'b1;
        offer_dac({24'h111111, 24'h222222});
        enable  = 1'b1;
        bclk_hi = 0;
        for (int n = 0; n <= 300; n++) begin
            @(negedge clk);
            if (n == 40) enable = 1'b0;
            if (n == 256) begin
                check("stop_valid", adc_valid, 1);
                check("stop_word", adc_data, {24'h111111, 24'h222222});
                check("stop_bclk", bclk, 0);
                check("stop_lrclk", lrclk, 0);
                check("stop_no_underrun", underrun, 0);
            end
            if (n > 256 && bclk) bclk_hi++;
        end
        check("idle_bclk_quiet", bclk_hi, 0);
        check("idle_lrclk", lrclk, 0);
        check("idle_valid_held", adc_valid, 1);

        // Stop then re-raise before the boundary: clocks continue without a gap
        do_reset();
        adc_ready = 1'b1;
        enable    = 1'b1;
        for (int n = 0; n <= 400; n++) begin
            @(negedge clk);
            if (n == 0) check("entry_underrun", underrun, 1);
            if (n == 40) enable = 1'b0;
            if (n == 80) enable = 1'b1;
            if (n == 256) begin
                check("rerun_boundary_valid", adc_valid, 1);
                check("rerun_boundary_underrun", underrun, 1);
            end
            if (n == 257) check("rerun_valid_drop", adc_valid, 0);
            if (n == 258) check("rerun_bclk_continues", bclk, 1);
            if (n == 384) check("rerun_lrclk_right", lrclk, 1);
        end

        // Asynchronous reset in the right slot
        do_reset();
        adc_ready = 1'b1;
        offer_dac({24'h000000, 24'hFFFFFF});
        enable = 1'b1;
        for (int n = 0; n <= 150; n++) begin
            @(negedge clk);
            if (n == 100) begin
                dac_valid = 1'b1;
                dac_data  = {24'h0F0F0F, 24'hF0F0F0};
            end
            if (n == 101) dac_valid = 1'b0;
        end
        check("pre_rst_bclk", bclk, 1);
        check("pre_rst_lrclk", lrclk, 1);
        check("pre_rst_sdata", sdata_o, 1);
        check("pre_rst_ready", dac_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_bclk", bclk, 0);
        check("async_lrclk", lrclk, 0);
        check("async_sdata", sdata_o, 0);
        check("async_valid", adc_valid, 0);
        check("async_ready", dac_ready, 1);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (adc_valid) vcnt++;
        end
        check("no_partial_frame", vcnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
